div_iter: RTL

//  Iterative radix-2 divider for the MIPS DIV/DIVU instructions, in the execute stage.
//  - The decoder asserts start_i while a divide sits in E.
//  - stall_o holds the pipeline: it is ORed into stallE and the front-end stalls.
//  - When finished, {hi,lo} is handed to the HI/LO write path.

---
 rtl/div_iter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/div_iter.sv
// ---------------------------------------------------------------------------
// div_iter
//   Iterative radix-2 restoring divider for the MIPS DIV/DIVU instructions,
//   living in the execute stage. A divide is accepted from IDLE, runs one
//   shift-subtract step per cycle for WIDTH cycles, then spends one DONE
//   cycle presenting the result with a single-cycle ready pulse.
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   start_i   divide instruction present in E (level, held while stalled)
//   signed_i  1 = DIV (two's complement), 0 = DIVU; sampled with start_i
//   flush_i   annul the in-flight divide / block acceptance
//   a_i       dividend (rs), sampled on accepted start
//   b_i       divisor (rt), sampled on accepted start
//   stall_o   pipeline stall request while a divide is being accepted/run
//   ready_o   one-cycle pulse, result_o valid, HI/LO may be written
//   result_o  {hi = remainder, lo = quotient}, held until next completion
// ---------------------------------------------------------------------------
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 signed_i,
  input  logic                 flush_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic                 stall_o,
  output logic                 ready_o,
  output logic [2*WIDTH-1:0]   result_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [2*WIDTH:0]      rem_q, rem_d;
  logic [WIDTH-1:0]      b_q, b_d;
  logic [WIDTH-1:0]      a_q, a_d;
  logic                  qneg_q, qneg_d;
  logic                  rneg_q, rneg_d;
  logic                  div0_q, div0_d;
  logic                  ready_q, ready_d;
  logic [2*WIDTH-1:0]    result_q, result_d;

  logic [WIDTH-1:0]      a_mag, b_mag;
  logic [2*WIDTH:0]      shifted, step_rem;
  logic [WIDTH:0]        upper, trial;
  logic                  take;
  logic [WIDTH-1:0]      quo_raw, rem_raw, quo_fix, rem_fix;
  logic [2*WIDTH-1:0]    final_res;

  // Operand magnitudes: only DIV treats the operands as two's complement.
  assign a_mag = (signed_i && a_i[WIDTH-1]) ? (~a_i + 1'b1) : a_i;
  assign b_mag = (signed_i && b_i[WIDTH-1]) ? (~b_i + 1'b1) : b_i;

  // One restoring step: shift left, try subtracting the divisor from the
  // upper half, keep the difference and set the quotient bit if it fits.
  always_comb begin
    shifted  = rem_q << 1;
    upper    = shifted[2*WIDTH:WIDTH];
    take     = (upper >= {1'b0, b_q});
    trial    = upper - {1'b0, b_q};
    step_rem = take ? {trial, shifted[WIDTH-1:1], 1'b1} : shifted;
  end

  // Result as it will look after the final step, with sign fixup applied.
  // Divide-by-zero bypasses the datapath and reports the raw dividend.
  always_comb begin
    quo_raw   = step_rem[WIDTH-1:0];
    rem_raw   = step_rem[2*WIDTH-1:WIDTH];
    quo_fix   = qneg_q ? (~quo_raw + 1'b1) : quo_raw;
    rem_fix   = rneg_q ? (~rem_raw + 1'b1) : rem_raw;
    final_res = div0_q ? {a_q, {WIDTH{1'b1}}} : {rem_fix, quo_fix};
  end

  // Next-state logic for the IDLE -> RUN -> DONE -> IDLE sequence.
  // ready is raised on the RUN->DONE transition so it is high exactly for
  // the DONE cycle, together with the freshly registered result.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    b_d      = b_q;
    a_d      = a_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    div0_d   = div0_q;
    ready_d  = 1'b0;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (start_i && !flush_i) begin
          state_d = RUN;
          cnt_d   = '0;
          rem_d   = {{(WIDTH+1){1'b0}}, a_mag};
          b_d     = b_mag;
          a_d     = a_i;
          qneg_d  = signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
          rneg_d  = signed_i & a_i[WIDTH-1];
          div0_d  = (b_i == '0);
        end
      end
      RUN: begin
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          rem_d = step_rem;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH-1)) begin
            state_d  = DONE;
            ready_d  = 1'b1;
            result_d = final_res;
          end
        end
      end
      DONE: begin
        // start_i is deliberately ignored here so the same instruction
        // cannot restart while E is advancing.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      b_q      <= '0;
      a_q      <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      div0_q   <= 1'b0;
      ready_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      b_q      <= b_d;
      a_q      <= a_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      div0_q   <= div0_d;
      ready_q  <= ready_d;
      result_q <= result_d;
    end
  end

  // Stall covers the accepting cycle as well as RUN; it drops in DONE so E
  // advances on the ready cycle, and is forced low while reset is asserted.
  assign stall_o  = ~rst & (((state_q == IDLE) & start_i & ~flush_i) | (state_q == RUN));
  assign ready_o  = ready_q;
  assign result_o = result_q;

endmodule
